// File: rtl/conv_pkg.sv
// Shared types and default geometry for the streaming convolution window logic.
package conv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_IMG_W  = 100;
  localparam int DEF_IMG_H  = 100;
  localparam int DEF_KERNEL = 3;
  localparam int DEF_STRIDE = 1;

  // Counter width for a range of v values; never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return ($clog2(v) < 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/conv_axis_counter.sv
// One raster axis: position counter plus stride-phase counter that marks window grid points.
module conv_axis_counter
  import conv_pkg::*;
#(
  parameter int DIM    = DEF_IMG_W,
  parameter int KERNEL = DEF_KERNEL,
  parameter int STRIDE = DEF_STRIDE,
  localparam int POS_W = clog2_min1(DIM),
  localparam int PH_W  = clog2_min1(STRIDE)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             step,
  input  logic             clear,
  output logic [POS_W-1:0] pos,
  output logic             wrap,
  output logic             on_grid
);

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(DIM - 1);
  localparam logic [POS_W-1:0] POS_KM1  = POS_W'(KERNEL - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(STRIDE - 1);

  logic [PH_W-1:0] phase;

  assign wrap    = step && (pos == POS_LAST);
  assign on_grid = (pos >= POS_KM1) && (phase == '0);

  // Phase stays 0 until the first full kernel span, then counts modulo STRIDE.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pos   <= '0;
      phase <= '0;
    end else if (clear || wrap) begin
      pos   <= '0;
      phase <= '0;
    end else if (step) begin
      pos <= pos + POS_W'(1);
      if (pos >= POS_KM1)
        phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
    end
  end

endmodule

// File: rtl/conv_window_valid_gen.sv
// Window-valid generator for raster-scanned frames; optional output-map coordinates
// are enabled with the CONV_WIN_COORD_OUT_EN macro.
module conv_window_valid_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int KERNEL = DEF_KERNEL,
  parameter int STRIDE = DEF_STRIDE,
  localparam int COL_W = clog2_min1(IMG_W),
  localparam int ROW_W = clog2_min1(IMG_H)
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Start,
  input  logic En,
  output logic Win_Valid,
  output logic Frame_Done,
  output logic Busy
`ifdef CONV_WIN_COORD_OUT_EN
  ,
  output logic [ROW_W-1:0] Win_Row,
  output logic [COL_W-1:0] Win_Col
`endif
);

  state_t state;
  logic   win_vld_p1;
  logic   frame_done_p1;

  logic             accept;
  logic             frame_arm;
  logic             row_step;
  logic             frame_last;
  logic [COL_W-1:0] col_pos;
  logic [ROW_W-1:0] row_pos;
  logic             col_wrap, row_wrap;
  logic             col_on_grid, row_on_grid;
  logic             unused_pos;

  assign accept     = En && (state == RUN);
  assign frame_arm  = Start && (state == IDLE);
  assign row_step   = accept && col_wrap;
  assign frame_last = row_wrap;
  assign unused_pos = ^{col_pos, row_pos};

  conv_axis_counter #(
    .DIM    (IMG_W),
    .KERNEL (KERNEL),
    .STRIDE (STRIDE)
  ) u_col (
    .Clk     (Clk),
    .Rst     (Rst),
    .step    (accept),
    .clear   (frame_arm),
    .pos     (col_pos),
    .wrap    (col_wrap),
    .on_grid (col_on_grid)
  );

  conv_axis_counter #(
    .DIM    (IMG_H),
    .KERNEL (KERNEL),
    .STRIDE (STRIDE)
  ) u_row (
    .Clk     (Clk),
    .Rst     (Rst),
    .step    (row_step),
    .clear   (frame_arm),
    .pos     (row_pos),
    .wrap    (row_wrap),
    .on_grid (row_on_grid)
  );

  // Stage p1: window flag and frame-done pulse for the pixel accepted this cycle.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state         <= IDLE;
      win_vld_p1    <= 1'b0;
      frame_done_p1 <= 1'b0;
    end else begin
      win_vld_p1    <= accept && col_on_grid && row_on_grid;
      frame_done_p1 <= frame_last;
      case (state)
        IDLE:    if (Start) state <= RUN;
        RUN:     if (frame_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign Win_Valid  = win_vld_p1;
  assign Frame_Done = frame_done_p1;
  assign Busy       = (state == RUN);

`ifdef CONV_WIN_COORD_OUT_EN
  logic [COL_W-1:0] oc_cnt;
  logic [ROW_W-1:0] or_cnt;

  // Output-map coordinates latch with the window flag; counters index grid points seen so far.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      oc_cnt  <= '0;
      or_cnt  <= '0;
      Win_Row <= '0;
      Win_Col <= '0;
    end else begin
      if (frame_done_p1) begin
        Win_Row <= '0;
        Win_Col <= '0;
      end
      if (accept && col_on_grid && row_on_grid) begin
        Win_Row <= or_cnt;
        Win_Col <= oc_cnt;
      end
      if (frame_last) begin
        oc_cnt <= '0;
        or_cnt <= '0;
      end else if (row_step) begin
        oc_cnt <= '0;
        if (row_on_grid) or_cnt <= or_cnt + ROW_W'(1);
      end else if (accept && col_on_grid) begin
        oc_cnt <= oc_cnt + COL_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_valid_gen.sv
// Directed bench for conv_window_valid_gen: default 100x100 k3 s1 and an 8x8 k3 s2 instance.
module tb_conv_window_valid_gen;

  localparam int N     = 10000;
  localparam int NVLD  = 9604;
  localparam int FIRST = 202;
  localparam int N8    = 64;

  logic clk = 1'b0;
  logic rst, start, en, start8, en8;
  logic win_valid, frame_done, busy;
  logic win_valid8, frame_done8, busy8;
`ifdef CONV_WIN_COORD_OUT_EN
  logic [6:0] win_row, win_col;
  logic [2:0] win_row8, win_col8;
`endif

  always #5 clk = ~clk;

  conv_window_valid_gen dut (
    .Clk        (clk),
    .Rst        (rst),
    .Start      (start),
    .En         (en),
    .Win_Valid  (win_valid),
    .Frame_Done (frame_done),
    .Busy       (busy)
`ifdef CONV_WIN_COORD_OUT_EN
    ,
    .Win_Row    (win_row),
    .Win_Col    (win_col)
`endif
  );

  conv_window_valid_gen #(
    .IMG_W  (8),
    .IMG_H  (8),
    .KERNEL (3),
    .STRIDE (2)
  ) dut8 (
    .Clk        (clk),
    .Rst        (rst),
    .Start      (start8),
    .En         (en8),
    .Win_Valid  (win_valid8),
    .Frame_Done (frame_done8),
    .Busy       (busy8)
`ifdef CONV_WIN_COORD_OUT_EN
    ,
    .Win_Row    (win_row8),
    .Win_Col    (win_col8)
`endif
  );

  int checks = 0;
  int errors = 0;

  bit model_run = 1'b0;
  int pix = 0, vld_cnt, fd_cnt, first_vld, fd_pix, gap_bad;
  bit m8_run = 1'b0;
  int pix8 = 0, vld8, fd8, pos_bad8, coord_bad8;

  task automatic clear_stats();
    vld_cnt = 0; fd_cnt = 0; first_vld = -1; fd_pix = -1; gap_bad = 0;
  endtask

  // One clock on the default instance: drive at negedge, observe at the next negedge.
  task automatic tick(input logic s, input logic e);
    bit acc;
    int idx;
    start = s; en = e;
    acc = model_run && e;
    idx = -1;
    if (acc) begin idx = pix; pix++; end
    if (!model_run && s) model_run = 1'b1;
    else if (acc && pix == N) begin model_run = 1'b0; pix = 0; end
    @(posedge clk);
    @(negedge clk);
    if (win_valid === 1'b1) begin
      vld_cnt++;
      if (first_vld < 0) first_vld = idx;
      if (!acc) gap_bad++;
    end
    if (frame_done === 1'b1) begin fd_cnt++; fd_pix = idx; end
  endtask

  task automatic tick8(input logic s, input logic e);
    bit acc;
    int idx, r, c;
    start8 = s; en8 = e;
    acc = m8_run && e;
    idx = -1;
    if (acc) begin idx = pix8; pix8++; end
    if (!m8_run && s) m8_run = 1'b1;
    else if (acc && pix8 == N8) begin m8_run = 1'b0; pix8 = 0; end
    @(posedge clk);
    @(negedge clk);
    r = idx / 8;
    c = idx % 8;
    if (win_valid8 === 1'b1) begin
      vld8++;
      if (idx < 0 || !(r inside {2, 4, 6}) || !(c inside {2, 4, 6})) pos_bad8++;
`ifdef CONV_WIN_COORD_OUT_EN
      if (win_row8 !== 3'((r - 2) / 2) || win_col8 !== 3'((c - 2) / 2)) coord_bad8++;
`endif
    end
    if (frame_done8 === 1'b1) fd8++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; en = 1'b0; start8 = 1'b0; en8 = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid: got %b expected 0", win_valid); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (busy8 !== 1'b0 || win_valid8 !== 1'b0) begin errors++; $display("FAIL reset_dut8: got busy %b valid %b expected 0 0", busy8, win_valid8); end
    rst = 1'b0;
    tick(1'b0, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_full_frame();
    clear_stats();
    tick(1'b1, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy_after_start: got %b expected 1", busy); end
    for (int i = 0; i < N; i++) tick(1'b0, 1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_at_done: got %b expected 0", busy); end
    checks++; if (first_vld !== FIRST) begin errors++; $display("FAIL full_first_valid: got %0d expected %0d", first_vld, FIRST); end
    checks++; if (vld_cnt !== NVLD) begin errors++; $display("FAIL full_valid_count: got %0d expected %0d", vld_cnt, NVLD); end
    checks++; if (fd_pix !== N - 1) begin errors++; $display("FAIL full_done_pixel: got %0d expected %0d", fd_pix, N - 1); end
    repeat (3) tick(1'b0, 1'b0);
    checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL full_done_count: got %0d expected 1", fd_cnt); end
  endtask

  task automatic test_stride();
    vld8 = 0; fd8 = 0; pos_bad8 = 0; coord_bad8 = 0;
    tick8(1'b1, 1'b0);
    for (int i = 0; i < N8; i++) tick8(1'b0, 1'b1);
    tick8(1'b0, 1'b0);
    checks++; if (vld8 !== 9) begin errors++; $display("FAIL stride_valid_count: got %0d expected 9", vld8); end
    checks++; if (pos_bad8 !== 0) begin errors++; $display("FAIL stride_valid_position: got %0d off-grid expected 0", pos_bad8); end
    checks++; if (fd8 !== 1) begin errors++; $display("FAIL stride_done_count: got %0d expected 1", fd8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL stride_busy_end: got %b expected 0", busy8); end
`ifdef CONV_WIN_COORD_OUT_EN
    checks++; if (coord_bad8 !== 0) begin errors++; $display("FAIL stride_coord: got %0d bad coordinates expected 0", coord_bad8); end
`endif
  endtask

  task automatic test_random_en();
    int budget;
    clear_stats();
    tick(1'b1, 1'b0);
    budget = 0;
    while (model_run && budget < 40000) begin
      tick(1'b0, ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0);
      budget++;
    end
    checks++; if (model_run) begin errors++; $display("FAIL random_timeout: got %0d pixels expected %0d", pix, N); end
    checks++; if (vld_cnt !== NVLD) begin errors++; $display("FAIL random_valid_count: got %0d expected %0d", vld_cnt, NVLD); end
    checks++; if (gap_bad !== 0) begin errors++; $display("FAIL random_valid_after_gap: got %0d expected 0", gap_bad); end
    checks++; if (first_vld !== FIRST) begin errors++; $display("FAIL random_first_valid: got %0d expected %0d", first_vld, FIRST); end
    checks++; if (fd_cnt !== 1 || fd_pix !== N - 1) begin errors++; $display("FAIL random_done: got count %0d pixel %0d expected 1 %0d", fd_cnt, fd_pix, N - 1); end
  endtask

  task automatic test_ignored_inputs();
    clear_stats();
    repeat (5) tick(1'b0, 1'b1);
    checks++; if (busy !== 1'b0 || vld_cnt !== 0) begin errors++; $display("FAIL idle_en: got busy %b valids %0d expected 0 0", busy, vld_cnt); end
    tick(1'b1, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_en_busy: got %b expected 1", busy); end
    for (int i = 0; i < N && model_run; i++) tick((i == 3000) ? 1'b1 : 1'b0, 1'b1);
    checks++; if (first_vld !== FIRST) begin errors++; $display("FAIL ignored_first_valid: got %0d expected %0d", first_vld, FIRST); end
    checks++; if (vld_cnt !== NVLD) begin errors++; $display("FAIL ignored_valid_count: got %0d expected %0d", vld_cnt, NVLD); end
    checks++; if (fd_cnt !== 1 || fd_pix !== N - 1) begin errors++; $display("FAIL ignored_done: got count %0d pixel %0d expected 1 %0d", fd_cnt, fd_pix, N - 1); end
  endtask

  task automatic test_abort();
    clear_stats();
    tick(1'b1, 1'b0);
    for (int i = 0; i < 5000; i++) tick(1'b0, 1'b1);
    start = 1'b0; en = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (win_valid !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_immediate: got valid %b done %b busy %b expected 0 0 0", win_valid, frame_done, busy); end
    model_run = 1'b0; pix = 0;
    repeat (2) @(negedge clk);
    checks++; if (frame_done !== 1'b0 || fd_cnt !== 0) begin errors++; $display("FAIL abort_no_done: got done %b count %0d expected 0 0", frame_done, fd_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    clear_stats();
    tick(1'b1, 1'b0);
    for (int i = 0; i < N; i++) tick(1'b0, 1'b1);
    checks++; if (vld_cnt !== NVLD || first_vld !== FIRST) begin errors++; $display("FAIL b2b_frame1: got valids %0d first %0d expected %0d %0d", vld_cnt, first_vld, NVLD, FIRST); end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL b2b_done_pulse: got %b expected 1", frame_done); end
    clear_stats();
    tick(1'b1, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy: got %b expected 1", busy); end
    for (int i = 0; i < N; i++) tick(1'b0, 1'b1);
    checks++; if (first_vld !== FIRST) begin errors++; $display("FAIL b2b_first_valid: got %0d expected %0d", first_vld, FIRST); end
    checks++; if (vld_cnt !== NVLD) begin errors++; $display("FAIL b2b_valid_count: got %0d expected %0d", vld_cnt, NVLD); end
    checks++; if (fd_cnt !== 1 || fd_pix !== N - 1) begin errors++; $display("FAIL b2b_done: got count %0d pixel %0d expected 1 %0d", fd_cnt, fd_pix, N - 1); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; en = 1'b0; start8 = 1'b0; en8 = 1'b0;
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_stride();
    test_random_en();
    test_ignored_inputs();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
